// File: rtl/lut_pkg.sv
// Package for the branch-target LUT bank.
// Holds the write FSM state encoding, the byte width constant and helpers
// that size the byte assembler from the target width.
package lut_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } wr_state_e;

    // Bytes needed to hold a w-bit target.
    function automatic int nbytes(input int w);
        return (w + BYTE_W - 1) / BYTE_W;
    endfunction

    // Width of a counter that can reach nb.
    function automatic int cnt_width(input int nb);
        return (nb < 1) ? 1 : $clog2(nb + 1);
    endfunction

endpackage

// File: rtl/lut_byte_assembler.sv
// Byte assembler for LUT entry writes.
// Collects bytes most significant first into a shift register and counts them.
// Ports:
//   clk_i    clock
//   rst_ni   synchronous active-low reset
//   clear_i  drop the partial entry and zero the counter
//   load_i   first byte of an entry: restart the register with byte_i
//   shift_i  further byte: shift left by one byte and append byte_i
//   byte_i   incoming data byte
//   data_o   low W bits of the assembled entry
//   cnt_o    bytes collected so far
//   full_o   all NB bytes collected
module lut_byte_assembler
    import lut_pkg::*;
#(
    parameter int W  = 10,
    parameter int NB = nbytes(W),
    parameter int CW = cnt_width(NB)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [W-1:0]      data_o,
    output logic [CW-1:0]     cnt_o,
    output logic              full_o
);

    localparam int SRW = NB * BYTE_W;

    logic [SRW-1:0] sr_q, sr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (load_i) begin
            sr_d  = SRW'(byte_i);
            cnt_d = CW'(1);
        end else if (shift_i) begin
            sr_d  = (sr_q << BYTE_W) | SRW'(byte_i);
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // Excess high bits of the first byte fall off here.
    assign data_o = sr_q[W-1:0];
    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q == CW'(NB));

endmodule

// File: rtl/lut_stream_bank.sv
// Branch-target LUT bank: 2**A entries of W-bit targets with per-entry valid
// bits. Entries are written byte-serially (MSB first) from the accumulator and
// read through a registered port by the PC-update logic.
// Optional feature macro: LUT_FWD_EN (forward a committing entry to a
// same-address read in the commit cycle).
// Ports:
//   clk         clock, all state on rising edge
//   Reset       synchronous active-low reset
//   Write_En    write transaction active; dropping it mid-transaction aborts
//   Wr_Addr     entry index, sampled with the first byte
//   Byte_in     data byte
//   Byte_Valid  Byte_in valid this cycle
//   Inval_All   clear every valid bit
//   Rd_En       read request
//   Rd_Addr     read index
//   Target      registered read data
//   Hit         registered "entry was valid"
//   Target_Vld  Target/Hit updated this cycle
//   Wr_Busy     write FSM not idle
//   Wr_Done     pulse after a successful commit
//   Err         pulse after an aborted or discarded write
//   Dbg_State   current write FSM state
// Handshake: a byte is accepted on any rising edge where Write_En and
// Byte_Valid are both high and the FSM is in IDLE or COLLECT; there is no
// back-pressure, so the source must not present bytes during COMMIT.
module lut_stream_bank
    import lut_pkg::*;
#(
    parameter int W = 10,
    parameter int A = 4
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Write_En,
    input  logic [A-1:0]      Wr_Addr,
    input  logic [BYTE_W-1:0] Byte_in,
    input  logic              Byte_Valid,
    input  logic              Inval_All,
    input  logic              Rd_En,
    input  logic [A-1:0]      Rd_Addr,
    output logic [W-1:0]      Target,
    output logic              Hit,
    output logic              Target_Vld,
    output logic              Wr_Busy,
    output logic              Wr_Done,
    output logic              Err,
    output logic [1:0]        Dbg_State
);

    localparam int NB    = nbytes(W);
    localparam int CW    = cnt_width(NB);
    localparam int DEPTH = 2 ** A;

    wr_state_e        state_q, state_d;
    logic [A-1:0]     addr_q, addr_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [W-1:0]     mem [DEPTH];

    logic [W-1:0]     tgt_q, tgt_d;
    logic             hit_q, hit_d;
    logic             tvld_q, tvld_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             asm_clear, asm_load, asm_shift;
    logic [W-1:0]     asm_data;
    logic [CW-1:0]    asm_cnt;
    logic             asm_full;
    logic             mem_we;

    lut_byte_assembler #(.W(W), .NB(NB), .CW(CW)) u_asm (
        .clk_i   (clk),
        .rst_ni  (Reset),
        .clear_i (asm_clear),
        .load_i  (asm_load),
        .shift_i (asm_shift),
        .byte_i  (Byte_in),
        .data_o  (asm_data),
        .cnt_o   (asm_cnt),
        .full_o  (asm_full)
    );

    // Write FSM next state and commit control.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        asm_clear = 1'b0;
        asm_load  = 1'b0;
        asm_shift = 1'b0;
        mem_we    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Write_En && Byte_Valid) begin
                    asm_load = 1'b1;
                    addr_d   = Wr_Addr;
                    state_d  = (NB == 1) ? COMMIT : COLLECT;
                end
            end
            COLLECT: begin
                if (!Write_En) begin
                    asm_clear = 1'b1;
                    err_d     = 1'b1;
                    state_d   = IDLE;
                end else if (Byte_Valid) begin
                    asm_shift = 1'b1;
                    if (asm_cnt == CW'(NB - 1)) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
                // Invalidate wins over the commit: the entry is dropped.
                if (Inval_All) begin
                    err_d = 1'b1;
                end else if (asm_full) begin
                    mem_we = 1'b1;
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        if (Inval_All) begin
            valid_d = '0;
        end else if (mem_we) begin
            valid_d[addr_q] = 1'b1;
        end
    end

    // Read port. valid_q/mem are the pre-edge contents, so a read alongside
    // Inval_All or a commit sees the old table unless forwarding is enabled.
    always_comb begin
        tgt_d  = tgt_q;
        hit_d  = hit_q;
        tvld_d = Rd_En;
        if (Rd_En) begin
`ifdef LUT_FWD_EN
            if (mem_we && (Rd_Addr == addr_q)) begin
                tgt_d = asm_data;
                hit_d = 1'b1;
            end else
`endif
            if (valid_q[Rd_Addr]) begin
                tgt_d = mem[Rd_Addr];
                hit_d = 1'b1;
            end else begin
                tgt_d = '0;
                hit_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            valid_q <= '0;
            tgt_q   <= '0;
            hit_q   <= 1'b0;
            tvld_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            tgt_q   <= tgt_d;
            hit_q   <= hit_d;
            tvld_q  <= tvld_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Data array has no reset; Reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (mem_we && Reset) begin
            mem[addr_q] <= asm_data;
        end
    end

    assign Target     = tgt_q;
    assign Hit        = hit_q;
    assign Target_Vld = tvld_q;
    assign Wr_Busy    = (state_q != IDLE);
    assign Wr_Done    = done_q;
    assign Err        = err_q;
    assign Dbg_State  = state_q;

endmodule

// File: tb/tb_lut_stream_bank.sv
module tb_lut_stream_bank;

  localparam int W = 10;
  localparam int A = 4;
  localparam int DEPTH = 16;

  logic         clk;
  logic         Reset;
  logic         Write_En;
  logic [A-1:0] Wr_Addr;
  logic [7:0]   Byte_in;
  logic         Byte_Valid;
  logic         Inval_All;
  logic         Rd_En;
  logic [A-1:0] Rd_Addr;
  logic [W-1:0] Target;
  logic         Hit;
  logic         Target_Vld;
  logic         Wr_Busy;
  logic         Wr_Done;
  logic         Err;
  logic [1:0]   Dbg_State;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: table contents and valid bits as the spec describes them.
  logic [W-1:0] ref_mem [DEPTH];
  bit           ref_vld [DEPTH];

  typedef struct {
    logic [3:0]   addr;
    logic [7:0]   b0;
    logic [7:0]   b1;
    logic [W-1:0] exp_tgt;
  } vec_t;

  vec_t vecs [5];

  lut_stream_bank #(.W(W), .A(A)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Write_En   (Write_En),
    .Wr_Addr    (Wr_Addr),
    .Byte_in    (Byte_in),
    .Byte_Valid (Byte_Valid),
    .Inval_All  (Inval_All),
    .Rd_En      (Rd_En),
    .Rd_Addr    (Rd_Addr),
    .Target     (Target),
    .Hit        (Hit),
    .Target_Vld (Target_Vld),
    .Wr_Busy    (Wr_Busy),
    .Wr_Done    (Wr_Done),
    .Err        (Err),
    .Dbg_State  (Dbg_State)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack2(input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] w;
    w = {b0, b1};
    return w[W-1:0];
  endfunction

  function automatic logic [W-1:0] model_tgt(input logic [3:0] a);
    return ref_vld[a] ? ref_mem[a] : '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_vld[i] = 1'b0;
  endtask

  // driver tasks
  task automatic do_read(input logic [3:0] a, input string name);
    Rd_En = 1'b1;
    Rd_Addr = a;
    tick();
    Rd_En = 1'b0;
    chk({name, ".vld"}, 32'(Target_Vld), 32'd1);
    chk({name, ".tgt"}, 32'(Target), 32'(model_tgt(a)));
    chk({name, ".hit"}, 32'(Hit), 32'(ref_vld[a]));
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] b0, input logic [7:0] b1,
                          input int stall, input bit abort);
    Write_En = 1'b1;
    Byte_Valid = 1'b1;
    Wr_Addr = a;
    Byte_in = b0;
    tick();
    Wr_Addr = ~a;  // address must only be sampled with the first byte
    for (int s = 0; s < stall; s++) begin
      Byte_Valid = 1'b0;
      Byte_in = 8'($urandom);
      tick();
      chk("stall.busy", 32'(Wr_Busy), 32'd1);
    end
    if (abort) begin
      Write_En = 1'b0;
      Byte_Valid = 1'b0;
      tick();
      chk("abort.err", 32'(Err), 32'd1);
      chk("abort.done", 32'(Wr_Done), 32'd0);
      chk("abort.busy", 32'(Wr_Busy), 32'd0);
    end else begin
      Byte_Valid = 1'b1;
      Byte_in = b1;
      tick();
      chk("commit.busy", 32'(Wr_Busy), 32'd1);
      Write_En = 1'b0;
      Byte_Valid = 1'b0;
      tick();
      chk("commit.done", 32'(Wr_Done), 32'd1);
      chk("commit.err", 32'(Err), 32'd0);
      chk("commit.idle", 32'(Wr_Busy), 32'd0);
      ref_mem[a] = pack2(b0, b1);
      ref_vld[a] = 1'b1;
    end
  endtask

  initial begin
    logic [W-1:0] held;
    logic [W-1:0] exp_fwd;

    Reset = 1'b0;
    Write_En = 1'b0;
    Wr_Addr = '0;
    Byte_in = '0;
    Byte_Valid = 1'b0;
    Inval_All = 1'b0;
    Rd_En = 1'b0;
    Rd_Addr = '0;
    model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    vecs[0] = '{addr: 4'd5, b0: 8'h02, b1: 8'hAB, exp_tgt: 10'h2AB};
    vecs[1] = '{addr: 4'd5, b0: 8'hFF, b1: 8'hAB, exp_tgt: 10'h3AB};
    vecs[2] = '{addr: 4'd6, b0: 8'h00, b1: 8'h00, exp_tgt: 10'h000};
    vecs[3] = '{addr: 4'd8, b0: 8'h01, b1: 8'hFF, exp_tgt: 10'h1FF};
    vecs[4] = '{addr: 4'd15, b0: 8'hFC, b1: 8'h01, exp_tgt: 10'h001};

    // reset state
    tick();
    tick();
    chk("rst.busy", 32'(Wr_Busy), 32'd0);
    chk("rst.tgt", 32'(Target), 32'd0);
    chk("rst.hit", 32'(Hit), 32'd0);
    chk("rst.tvld", 32'(Target_Vld), 32'd0);
    chk("rst.done", 32'(Wr_Done), 32'd0);
    chk("rst.err", 32'(Err), 32'd0);
    Reset = 1'b1;
    tick();
    do_read(4'd3, "rd3_after_rst");

    // table-driven writes
    for (int i = 0; i < 5; i++) begin
      do_write(vecs[i].addr, vecs[i].b0, vecs[i].b1, 0, 1'b0);
      Rd_En = 1'b1;
      Rd_Addr = vecs[i].addr;
      tick();
      Rd_En = 1'b0;
      chk("tbl.tgt", 32'(Target), 32'(vecs[i].exp_tgt));
      chk("tbl.hit", 32'(Hit), 32'd1);
    end

    // Rd_En low holds Target/Hit
    held = Target;
    tick();
    chk("hold.tvld", 32'(Target_Vld), 32'd0);
    chk("hold.tgt", 32'(Target), 32'(held));
    chk("hold.hit", 32'(Hit), 32'd1);

    // stall tolerated, then abort
    do_write(4'd7, 8'h01, 8'h55, 3, 1'b0);
    do_read(4'd7, "stall7");
    chk("stall7.abs", 32'(Target), 32'h155);
    do_write(4'd7, 8'h03, 8'h00, 0, 1'b1);
    do_read(4'd7, "abort7");
    chk("abort7.abs", 32'(Target), 32'h155);

    // fill all entries, read both directions
    for (int i = 0; i < DEPTH; i++)
      do_write(4'(i), 8'($urandom), 8'($urandom), 0, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_read(4'(i), "fill_up");
    for (int i = DEPTH - 1; i >= 0; i--) do_read(4'(i), "fill_dn");

    // Inval_All with a simultaneous read returns pre-clear contents
    Inval_All = 1'b1;
    Rd_En = 1'b1;
    Rd_Addr = 4'd4;
    tick();
    Inval_All = 1'b0;
    Rd_En = 1'b0;
    chk("inv_rd.tgt", 32'(Target), 32'(ref_mem[4]));
    chk("inv_rd.hit", 32'(Hit), 32'd1);
    model_clear();
    for (int i = 0; i < DEPTH; i++) do_read(4'(i), "after_inv");

    // Inval_All during COMMIT of address 2
    Write_En = 1'b1;
    Byte_Valid = 1'b1;
    Wr_Addr = 4'd2;
    Byte_in = 8'h01;
    tick();
    Byte_in = 8'h23;
    tick();
    Write_En = 1'b0;
    Byte_Valid = 1'b0;
    Inval_All = 1'b1;
    tick();
    Inval_All = 1'b0;
    chk("invc.err", 32'(Err), 32'd1);
    chk("invc.done", 32'(Wr_Done), 32'd0);
    do_read(4'd2, "invc_rd2");

    // read in the COMMIT cycle of address 9
    do_write(4'd9, 8'h01, 8'h11, 0, 1'b0);
    Write_En = 1'b1;
    Byte_Valid = 1'b1;
    Wr_Addr = 4'd9;
    Byte_in = 8'h02;
    tick();
    Byte_in = 8'h22;
    tick();
    Write_En = 1'b0;
    Byte_Valid = 1'b0;
    Rd_En = 1'b1;
    Rd_Addr = 4'd9;
    tick();
    Rd_En = 1'b0;
`ifdef LUT_FWD_EN
    exp_fwd = 10'h222;
`else
    exp_fwd = 10'h111;
`endif
    chk("fwd.tgt", 32'(Target), 32'(exp_fwd));
    chk("fwd.hit", 32'(Hit), 32'd1);
    chk("fwd.done", 32'(Wr_Done), 32'd1);
    ref_mem[9] = 10'h222;
    do_read(4'd9, "fwd_after");

    // randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      int op;
      op = int'($urandom_range(0, 15));
      if (op == 0) begin
        Inval_All = 1'b1;
        tick();
        Inval_All = 1'b0;
        model_clear();
      end else if (op < 9) begin
        do_write(4'($urandom), 8'($urandom), 8'($urandom),
                 int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
      end else begin
        do_read(4'($urandom), "rand_rd");
      end
    end

    // reset mid-transaction discards the partial entry, no pulses
    do_write(4'd4, 8'h03, 8'h21, 0, 1'b0);
    Write_En = 1'b1;
    Byte_Valid = 1'b1;
    Wr_Addr = 4'd4;
    Byte_in = 8'h01;
    tick();
    Write_En = 1'b0;
    Byte_Valid = 1'b0;
    Reset = 1'b0;
    tick();
    chk("mrst.err", 32'(Err), 32'd0);
    chk("mrst.done", 32'(Wr_Done), 32'd0);
    chk("mrst.busy", 32'(Wr_Busy), 32'd0);
    Reset = 1'b1;
    model_clear();
    tick();
    chk("mrst.err2", 32'(Err), 32'd0);
    do_read(4'd4, "mrst_rd4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
